uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arb.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Round-robin arbiter that feeds bytes from NUM_REQ requesters into a single
// UART serializer. A granted requester keeps the serializer until it drops
// valid, sends EOP_CHAR, or has sent MAX_BURST bytes.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   req_valid   [NUM_REQ]   requester i has a byte pending
//   req_data    [8*NUM_REQ] requester i byte on bits [8i+7:8i]
//   req_accept  [NUM_REQ]   one-cycle pulse: byte of requester i consumed
//   tx_data     [8]         byte to serializer, zero unless tx_en
//   tx_en                   one-cycle start pulse to serializer
//   tx_busy                 serializer busy (rises within 1 cycle of tx_en)
//   grant_id    [2]         current or last granted requester
//   locked                  a requester holds the grant
//   tx_count    [16]        total bytes issued, wrapping
//   fsm_state   [2]         FSM state for observation (0 IDLE, 1 SEND, 2 GAP, 3 WAIT)
//
// Handshake: a byte moves in the cycle where req_valid[g] and req_accept[g]
// are both high; req_accept is only ever raised together with tx_en, and the
// requester must hold req_data stable while req_valid is high until accepted.
module uart_tx_arb #(
    parameter int         NUM_REQ   = 3,
    parameter int         MAX_BURST = 16,
    parameter logic [7:0] EOP_CHAR  = 8'h0A
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_accept,
    output logic [7:0]           tx_data,
    output logic                 tx_en,
    input  logic                 tx_busy,
    output logic [1:0]           grant_id,
    output logic                 locked,
    output logic [15:0]          tx_count,
    output logic [1:0]           fsm_state
);

    localparam int IW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t         state_q;
    // The grant register doubles as the round-robin pointer (last_grant):
    // both are loaded at the same moment and reset to the same value.
    logic [IW-1:0]  gnt_q;
    logic [7:0]     burst_cnt_q;
    logic [7:0]     last_byte_q;
    logic [15:0]    count_q;

    logic           rr_found;
    logic [IW-1:0]  rr_winner;
    logic           sel_valid;
    logic [7:0]     sel_data;
    logic           issue;

    // Round-robin search starting one past the last grant, ascending with wrap.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = gnt_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!rr_found && req_valid[i] &&
                    (((int'(gnt_q) + k) % NUM_REQ) == i)) begin
                    rr_found  = 1'b1;
                    rr_winner = IW'(i);
                end
            end
        end
    end

    // Mux the granted requester's valid and data.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q == IW'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    // A byte goes out in SEND when the owner is valid and the serializer is
    // free. Reset suppresses it so nothing is issued in a reset cycle.
    assign issue = (state_q == SEND) && sel_valid && !tx_busy && !rst;

    always_comb begin
        req_accept = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_accept[i] = issue && (gnt_q == IW'(i));
        end
    end

    assign tx_en     = issue;
    assign tx_data   = issue ? sel_data : 8'h00;
    assign locked    = (state_q != IDLE);
    assign grant_id  = 2'(gnt_q);
    assign tx_count  = count_q;
    assign fsm_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= IW'(NUM_REQ - 1);
            burst_cnt_q <= 8'd0;
            last_byte_q <= 8'd0;
            count_q     <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rr_found && !tx_busy) begin
                        gnt_q       <= rr_winner;
                        burst_cnt_q <= 8'd0;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (!sel_valid) begin
                        // Owner went away: give the grant back without a byte.
                        state_q <= IDLE;
                    end else if (issue) begin
                        burst_cnt_q <= burst_cnt_q + 8'd1;
                        count_q     <= count_q + 16'd1;
                        last_byte_q <= sel_data;
                        state_q     <= GAP;
                    end
                end
                GAP: begin
                    // Gives the serializer its cycle to raise tx_busy.
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (!tx_busy) begin
                        if ((last_byte_q == EOP_CHAR) ||
                            (burst_cnt_q == 8'(MAX_BURST))) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= SEND;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb
// Bench for uart_tx_arb: table of single-byte grants, hand-written corner
// sequences (burst limit, EOP release, busy hold, reset mid-burst, counter
// wrap) and randomized multi-requester traffic checked against a
// message-level arbitration model.
module tb_uart_tx_arb;

    localparam int         NR   = 3;
    localparam int         MAXB = 16;
    localparam logic [7:0] EOP  = 8'h0A;

    logic                clk;
    logic                rst;
    logic [NR-1:0]       req_valid;
    logic [8*NR-1:0]     req_data;
    logic [NR-1:0]       req_accept;
    logic [7:0]          tx_data;
    logic                tx_en;
    logic                tx_busy = 1'b0;
    logic [1:0]          grant_id;
    logic                locked;
    logic [15:0]         tx_count;
    logic [1:0]          fsm_state;

    uart_tx_arb #(
        .NUM_REQ   (NR),
        .MAX_BURST (MAXB),
        .EOP_CHAR  (EOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_accept (req_accept),
        .tx_data    (tx_data),
        .tx_en      (tx_en),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .locked     (locked),
        .tx_count   (tx_count),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- serializer model ----------------
    // Auto mode: busy rises the cycle after tx_en and lasts busy_len cycles
    // (or a random 1..8 when busy_rand). Manual mode: tx_busy = man_busy.
    bit ser_mode  = 1'b0;
    bit man_busy  = 1'b0;
    bit busy_rand = 1'b0;
    int busy_len  = 10;
    int busy_cnt  = 0;
    logic en_prev = 1'b0;

    always @(negedge clk) en_prev = tx_en;

    always @(posedge clk) begin
        #1;
        if (!ser_mode && en_prev)
            busy_cnt = busy_rand ? int'($urandom_range(1, 8)) : busy_len;
        else if (busy_cnt > 0)
            busy_cnt = busy_cnt - 1;
        tx_busy = ser_mode ? man_busy : (busy_cnt != 0);
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int m_last = NR - 1;   // model round-robin pointer
    int m_count = 0;       // model byte counter
    logic [9:0] exp_q[$];  // {grant, byte}
    logic [7:0] rq [NR][$];

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_last = NR - 1;
        m_count = 0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!locked && !tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", 32'(ok), 1);
    endtask

    task automatic wait_en(input int bound, output int lat);
        lat = 0;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            if (tx_en) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (rq[i].size() > 0);
            req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
        end
    endtask

    // Message-level arbitration: winner is the first non-empty requester
    // after the last grant; it keeps sending until EOP, MAXB bytes, or empty.
    task automatic build_expected();
        logic [7:0] mq [NR][$];
        int last;
        int g;
        int cnt;
        int c;
        int left;
        bit done;
        logic [7:0] b;
        for (int i = 0; i < NR; i++) mq[i] = rq[i];
        last = m_last;
        left = 0;
        for (int i = 0; i < NR; i++) left += mq[i].size();
        while (left > 0) begin
            g = -1;
            for (int k = 1; k <= NR; k++) begin
                c = (last + k) % NR;
                if (g < 0 && mq[c].size() > 0) g = c;
            end
            last = g;
            cnt = 0;
            done = 1'b0;
            while (!done) begin
                b = mq[g].pop_front();
                exp_q.push_back({2'(g), b});
                left--;
                cnt++;
                if (b == EOP || cnt == MAXB || mq[g].size() == 0) done = 1'b1;
            end
        end
        m_last = last;
    endtask

    task automatic run_traffic(input int budget);
        int cyc;
        int last_en;
        int pop_idx;
        int nexp;
        int left;
        logic [9:0] e;
        build_expected();
        nexp = exp_q.size();
        cyc = 0;
        last_en = -100;
        @(negedge clk);
        drive_reqs();
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            pop_idx = -1;
            check("accept_onehot", 32'($countones(req_accept) <= 1), 1);
            check("accept_vs_grant", 32'(req_accept),
                  tx_en ? 32'(3'(1) << grant_id) : 0);
            if (tx_en) begin
                check("tx_spacing", 32'(cyc - last_en >= 3), 1);
                check("locked_on_tx", 32'(locked), 1);
                last_en = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_tx", 32'({grant_id, tx_data}), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_grant_byte", 32'({grant_id, tx_data}), 32'(e));
                end
                pop_idx = int'(grant_id);
            end
            @(posedge clk);
            #1;
            if (pop_idx >= 0 && rq[pop_idx].size() > 0) void'(rq[pop_idx].pop_front());
            drive_reqs();
            left = 0;
            for (int i = 0; i < NR; i++) left += rq[i].size();
            if (left == 0 && exp_q.size() == 0) break;
        end
        check("traffic_drained", exp_q.size(), 0);
        exp_q.delete();
        for (int i = 0; i < NR; i++) rq[i].delete();
        req_valid = '0;
        wait_idle();
        m_count += nexp;
        check("traffic_count", 32'(tx_count), 32'(16'(m_count)));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NR-1:0]   mask;
        logic [8*NR-1:0] data;
        logic [1:0]      exp_grant;
        logic [7:0]      exp_data;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];
    logic [NR-1:0] v_masks  [NV] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b100,
                                     3'b011, 3'b001, 3'b110, 3'b101, 3'b010, 3'b011};
    logic [1:0]    v_grants [NV] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2,
                                     2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0};

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int n;
        int viol;
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;

        for (int i = 0; i < NV; i++) begin
            vecs[i].mask      = v_masks[i];
            vecs[i].data      = {8'(8'h30 + 3*i + 2), 8'(8'h30 + 3*i + 1), 8'(8'h30 + 3*i)};
            vecs[i].exp_grant = v_grants[i];
            vecs[i].exp_data  = 8'(8'h30 + 3*i + int'(v_grants[i]));
        end

        // Reset values.
        do_reset();
        @(negedge clk);
        check("rst_tx_en", 32'(tx_en), 0);
        check("rst_accept", 32'(req_accept), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_grant", 32'(grant_id), NR - 1);
        check("rst_locked", 32'(locked), 0);
        check("rst_count", 32'(tx_count), 0);
        check("rst_state", 32'(fsm_state), 0);

        // Single-byte grants, serializer busy 10 cycles after each tx_en.
        busy_len = 10;
        for (int i = 0; i < NV; i++) begin
            wait_idle();
            req_data  = vecs[i].data;
            req_valid = vecs[i].mask;
            wait_en(50, lat);
            check("vec_latency", lat, 1);
            check("vec_accept", 32'(req_accept), 32'(3'(1) << vecs[i].exp_grant));
            check("vec_grant", 32'(grant_id), 32'(vecs[i].exp_grant));
            check("vec_data", 32'(tx_data), 32'(vecs[i].exp_data));
            @(posedge clk);
            #1 req_valid = '0;
            wait_idle();
            m_count++;
            m_last = int'(vecs[i].exp_grant);
            check("vec_count", 32'(tx_count), m_count);
        end

        // Burst limit: requester 1 streams 20 bytes, requester 2 waiting.
        do_reset();
        for (int i = 0; i < 20; i++) rq[1].push_back(8'h41);
        rq[2].push_back(8'h52);
        rq[2].push_back(8'h0A);
        run_traffic(2000);

        // EOP release: requester 1 must be served between 0x0A and 0x49.
        rq[0].push_back(8'h48);
        rq[0].push_back(8'h0A);
        rq[0].push_back(8'h49);
        rq[1].push_back(8'h31);
        rq[1].push_back(8'h0A);
        run_traffic(500);

        // Randomized traffic with random serializer busy time.
        busy_rand = 1'b1;
        for (int r = 0; r < 8; r++) begin
            n = 0;
            for (int i = 0; i < NR; i++) begin
                int len;
                len = int'($urandom_range(0, 20));
                for (int j = 0; j < len; j++) begin
                    rq[i].push_back(($urandom_range(0, 3) == 0) ? EOP : 8'($urandom_range(0, 255)));
                end
                n += len;
            end
            run_traffic(15 * n + 100);
        end
        busy_rand = 1'b0;

        // Serializer held busy: nothing may be issued.
        ser_mode = 1'b1;
        man_busy = 1'b1;
        do_reset();
        @(negedge clk);
        req_data  = {8'h0A, 8'h0A, 8'h0A};
        req_valid = 3'b111;
        viol = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx_en || req_accept != 0 || locked) viol++;
        end
        check("busy_hold_quiet", viol, 0);
        man_busy = 1'b0;
        @(posedge clk);
        wait_en(5, lat);
        check("busy_release_latency", 32'(lat >= 1 && lat <= 2), 1);
        check("busy_release_grant", 32'(grant_id), 0);
        @(posedge clk);
        #1 req_valid = '0;
        wait_idle();

        // Reset in WAIT while the serializer is busy.
        do_reset();
        @(negedge clk);
        req_data  = {8'h00, 8'h00, 8'h55};
        req_valid = 3'b001;
        wait_en(5, lat);
        check("mid_first_tx", lat, 1);
        man_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_in_wait", 32'(fsm_state), 3);
        check("mid_count_pre", 32'(tx_count), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_locked", 32'(locked), 0);
        check("mid_count", 32'(tx_count), 0);
        check("mid_grant", 32'(grant_id), NR - 1);
        viol = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (tx_en || locked) viol++;
        end
        check("mid_no_tx_while_busy", viol, 0);
        man_busy = 1'b0;
        @(posedge clk);
        wait_en(5, lat);
        check("mid_resume_latency", 32'(lat >= 1 && lat <= 2), 1);
        check("mid_resume_byte", 32'({grant_id, tx_data}), 32'({2'd0, 8'h55}));
        @(posedge clk);
        #1 req_valid = '0;
        wait_idle();
        ser_mode = 1'b0;

        // Counter wrap.
        @(negedge clk);
        force dut.count_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.count_q;
        @(negedge clk);
        check("wrap_preset", 32'(tx_count), 32'hFFFF);
        req_data  = {8'h00, 8'h00, 8'h0A};
        req_valid = 3'b001;
        wait_en(5, lat);
        check("wrap_tx", lat, 1);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("wrap_count", 32'(tx_count), 0);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
